// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the three-client bus arbiter: FSM states, client
// indices and the fixed bus access size used for line bursts.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_e;

    localparam logic [1:0] IC = 2'd0;
    localparam logic [1:0] DC = 2'd1;
    localparam logic [1:0] UC = 2'd2;

    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/arb_prio3.sv
// Fixed-priority encoder for three clients: uc > dc > ic.
module arb_prio3
    import bus_arbiter_pkg::*;
(
    input  logic [2:0] i_req,
    output logic [2:0] o_grant,
    output logic [1:0] o_idx,
    output logic       o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = IC;
        if (i_req[UC]) begin
            o_grant[UC] = 1'b1;
            o_idx       = UC;
        end else if (i_req[DC]) begin
            o_grant[DC] = 1'b1;
            o_idx       = DC;
        end else if (i_req[IC]) begin
            o_grant[IC] = 1'b1;
            o_idx       = IC;
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates icache, dcache and uncached clients onto a single sram-like
// master port, one transaction outstanding, with line bursts of LINE_WORDS.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic                          clk,
    input  logic                          resetn,

    input  logic                          ic_req,
    input  logic                          ic_wr,
    input  logic                          ic_burst,
    input  logic [1:0]                    ic_size,
    input  logic [31:0]                   ic_addr,
    input  logic [31:0]                   ic_wdata,
    output logic                          ic_grant,
    output logic                          ic_rvalid,
    output logic                          ic_fin,

    input  logic                          dc_req,
    input  logic                          dc_wr,
    input  logic                          dc_burst,
    input  logic [1:0]                    dc_size,
    input  logic [31:0]                   dc_addr,
    input  logic [31:0]                   dc_wdata,
    output logic                          dc_grant,
    output logic                          dc_rvalid,
    output logic                          dc_fin,

    input  logic                          uc_req,
    input  logic                          uc_wr,
    input  logic                          uc_burst,
    input  logic [1:0]                    uc_size,
    input  logic [31:0]                   uc_addr,
    input  logic [31:0]                   uc_wdata,
    output logic                          uc_grant,
    output logic                          uc_rvalid,
    output logic                          uc_fin,

    output logic [$clog2(LINE_WORDS)-1:0] beat,
    output logic [31:0]                   rdata,

    output logic                          bus_req,
    output logic                          bus_wr,
    output logic [1:0]                    bus_size,
    output logic [31:0]                   bus_addr,
    output logic [31:0]                   bus_wdata,
    input  logic [31:0]                   bus_rdata,
    input  logic                          bus_addr_ok,
    input  logic                          bus_data_ok
);

    localparam int unsigned BW = $clog2(LINE_WORDS);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [BW-1:0]   r_beat;
    logic            r_wr;
    logic            r_burst;
    logic [1:0]      r_size;
    logic [31:0]     r_addr;
    logic [1:0]      r_owner;

    logic [2:0]      w_req;
    logic [2:0]      w_prio_gnt;
    logic [1:0]      w_prio_idx;
    logic            w_any;
    logic [2:0]      w_gnt;
    logic            w_take;
    logic            w_beat_inc;
    logic            w_rvalid;
    logic            w_fin;
    logic            w_last;
    logic [31:0]     w_burst_addr;
    logic [31:0]     w_owner_wdata;
    logic            w_sel_wr;
    logic            w_sel_burst;
    logic [1:0]      w_sel_size;
    logic [31:0]     w_sel_addr;

    assign w_req = {uc_req, dc_req, ic_req};

    arb_prio3 u_prio (
        .i_req   (w_req),
        .o_grant (w_prio_gnt),
        .o_idx   (w_prio_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_wr    = ic_wr;
        w_sel_burst = ic_burst;
        w_sel_size  = ic_size;
        w_sel_addr  = ic_addr;
        case (w_prio_idx)
            UC: begin
                w_sel_wr    = uc_wr;
                w_sel_burst = uc_burst;
                w_sel_size  = uc_size;
                w_sel_addr  = uc_addr;
            end
            DC: begin
                w_sel_wr    = dc_wr;
                w_sel_burst = dc_burst;
                w_sel_size  = dc_size;
                w_sel_addr  = dc_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_owner)
            UC:      w_owner_wdata = uc_wdata;
            DC:      w_owner_wdata = dc_wdata;
            default: w_owner_wdata = ic_wdata;
        endcase
    end

    // Line base with the beat index spliced in gives base + beat*4 without an adder.
    assign w_burst_addr = {r_addr[31:BW+2], r_beat, 2'b00};
    assign w_last       = !r_burst || (r_beat == BW'(LINE_WORDS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_take      = 1'b0;
        w_beat_inc  = 1'b0;
        w_rvalid    = 1'b0;
        w_fin       = 1'b0;
        bus_req     = 1'b0;
        bus_wr      = 1'b0;
        bus_size    = '0;
        bus_addr    = '0;
        bus_wdata   = '0;
        rdata       = '0;
        case (r_state)
            S_IDLE: begin
                if (resetn && w_any) begin
                    w_gnt       = w_prio_gnt;
                    w_take      = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = r_wr;
                bus_size  = r_burst ? SIZE_WORD : r_size;
                bus_addr  = r_burst ? w_burst_addr : r_addr;
                bus_wdata = w_owner_wdata;
                if (bus_addr_ok) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    if (!r_wr) begin
                        w_rvalid = 1'b1;
                        rdata    = bus_rdata;
                    end
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_beat_inc  = 1'b1;
                        w_state_nxt = S_ADDR;
                    end
                end
            end
            S_DONE: begin
                w_fin       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_wr    <= 1'b0;
            r_burst <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_owner <= IC;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_wr    <= w_sel_wr;
                r_burst <= w_sel_burst;
                r_size  <= w_sel_size;
                r_addr  <= w_sel_addr;
                r_owner <= w_prio_idx;
                r_beat  <= '0;
            end else if (w_beat_inc) begin
                r_beat  <= r_beat + 1'b1;
            end
        end
    end

    assign beat      = r_beat;

    assign ic_grant  = w_gnt[IC];
    assign dc_grant  = w_gnt[DC];
    assign uc_grant  = w_gnt[UC];

    assign ic_rvalid = w_rvalid && (r_owner == IC);
    assign dc_rvalid = w_rvalid && (r_owner == DC);
    assign uc_rvalid = w_rvalid && (r_owner == UC);

    assign ic_fin    = w_fin && (r_owner == IC);
    assign dc_fin    = w_fin && (r_owner == DC);
    assign uc_fin    = w_fin && (r_owner == UC);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: cycle tables for single accesses and
// priority, plus hand sequences for bursts, slave stalls and reset.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ic_req, ic_wr, ic_burst, dc_req, dc_wr, dc_burst, uc_req, uc_wr, uc_burst;
    logic [1:0]  ic_size, dc_size, uc_size;
    logic [31:0] ic_addr, dc_addr, uc_addr, ic_wdata, dc_wdata, uc_wdata;
    logic        ic_grant, dc_grant, uc_grant, ic_rvalid, dc_rvalid, uc_rvalid;
    logic        ic_fin, dc_fin, uc_fin;
    logic [2:0]  beat;
    logic [31:0] rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_addr_ok, bus_data_ok;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.LINE_WORDS(8)) dut (
        .clk(clk), .resetn(resetn),
        .ic_req(ic_req), .ic_wr(ic_wr), .ic_burst(ic_burst), .ic_size(ic_size),
        .ic_addr(ic_addr), .ic_wdata(ic_wdata), .ic_grant(ic_grant),
        .ic_rvalid(ic_rvalid), .ic_fin(ic_fin),
        .dc_req(dc_req), .dc_wr(dc_wr), .dc_burst(dc_burst), .dc_size(dc_size),
        .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_grant(dc_grant),
        .dc_rvalid(dc_rvalid), .dc_fin(dc_fin),
        .uc_req(uc_req), .uc_wr(uc_wr), .uc_burst(uc_burst), .uc_size(uc_size),
        .uc_addr(uc_addr), .uc_wdata(uc_wdata), .uc_grant(uc_grant),
        .uc_rvalid(uc_rvalid), .uc_fin(uc_fin),
        .beat(beat), .rdata(rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );

    // Three-bit fields are ordered {uc, dc, ic}.
    typedef struct {
        logic [2:0]  req;
        logic [2:0]  wr;
        logic        aok;
        logic        dok;
        logic [31:0] brd;
        logic [2:0]  gnt;
        logic [2:0]  rv;
        logic [2:0]  fin;
        logic        breq;
        logic [31:0] baddr;
        logic [31:0] rdat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] req, input logic [2:0] wr, input logic aok,
                       input logic dok, input logic [31:0] brd, input logic [2:0] gnt,
                       input logic [2:0] rv, input logic [2:0] fin, input logic breq,
                       input logic [31:0] baddr, input logic [31:0] rdat);
        vec_t v;
        v.req = req; v.wr = wr; v.aok = aok; v.dok = dok; v.brd = brd;
        v.gnt = gnt; v.rv = rv; v.fin = fin; v.breq = breq; v.baddr = baddr; v.rdat = rdat;
        vq.push_back(v);
    endtask

    task automatic drive_idle();
        {uc_req, dc_req, ic_req} = 3'b000;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
    endtask

    function automatic logic [2:0] gnt3();
        return {uc_grant, dc_grant, ic_grant};
    endfunction
    function automatic logic [2:0] rv3();
        return {uc_rvalid, dc_rvalid, ic_rvalid};
    endfunction
    function automatic logic [2:0] fin3();
        return {uc_fin, dc_fin, ic_fin};
    endfunction

    initial begin
        int n_rv;
        resetn = 1'b0;
        {uc_wr, dc_wr, ic_wr} = '0;
        {uc_burst, dc_burst, ic_burst} = '0;
        uc_size = 2'b10; dc_size = 2'b10; ic_size = 2'b10;
        uc_addr = 32'hBFAF_8000; dc_addr = 32'h0000_1234; ic_addr = 32'h0000_0040;
        uc_wdata = 32'h0; dc_wdata = 32'h0; ic_wdata = 32'h0;
        drive_idle();
        {uc_req, dc_req, ic_req} = 3'b111;

        // Reset state with all requests pending: nothing may be granted.
        #1;
        chk("rst_gnt", 32'(gnt3()), 32'h0);
        @(posedge clk); #1;
        chk("rst_ctl", 32'({gnt3(), rv3(), fin3(), bus_req, beat}), 32'h0);
        @(negedge clk);
        drive_idle();
        resetn = 1'b1;

        // uc single read, minimum latency
        add(3'b100, 3'b000, 0, 0, 32'h0,          3'b100, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        add(3'b100, 3'b000, 1, 0, 32'h0,          3'b000, 3'b000, 3'b000, 1, 32'hBFAF_8000, 32'h0);
        add(3'b100, 3'b000, 0, 1, 32'hDEAD_BEEF,  3'b000, 3'b100, 3'b000, 0, 32'h0,          32'hDEAD_BEEF);
        add(3'b000, 3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 3'b100, 0, 32'h0,          32'h0);
        add(3'b000, 3'b000, 0, 1, 32'h0,          3'b000, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        // dc single write; addr_ok during DATA is ignored, no rvalid
        add(3'b010, 3'b010, 0, 0, 32'h0,          3'b010, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        add(3'b010, 3'b010, 1, 0, 32'h0,          3'b000, 3'b000, 3'b000, 1, 32'h0000_1234, 32'h0);
        add(3'b010, 3'b010, 1, 0, 32'h0,          3'b000, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        add(3'b010, 3'b010, 0, 1, 32'hCAFE_F00D,  3'b000, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        add(3'b000, 3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 3'b010, 0, 32'h0,          32'h0);
        add(3'b000, 3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        // simultaneous requests: uc, then dc, then ic
        add(3'b111, 3'b000, 0, 0, 32'h0,          3'b100, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        add(3'b111, 3'b000, 1, 0, 32'h0,          3'b000, 3'b000, 3'b000, 1, 32'hBFAF_8000, 32'h0);
        add(3'b111, 3'b000, 0, 1, 32'h1111_1111,  3'b000, 3'b100, 3'b000, 0, 32'h0,          32'h1111_1111);
        add(3'b011, 3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 3'b100, 0, 32'h0,          32'h0);
        add(3'b011, 3'b000, 0, 0, 32'h0,          3'b010, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        add(3'b011, 3'b000, 1, 0, 32'h0,          3'b000, 3'b000, 3'b000, 1, 32'h0000_1234, 32'h0);
        add(3'b011, 3'b000, 0, 1, 32'h2222_2222,  3'b000, 3'b010, 3'b000, 0, 32'h0,          32'h2222_2222);
        add(3'b001, 3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 3'b010, 0, 32'h0,          32'h0);
        add(3'b001, 3'b000, 0, 0, 32'h0,          3'b001, 3'b000, 3'b000, 0, 32'h0,          32'h0);
        add(3'b001, 3'b000, 1, 0, 32'h0,          3'b000, 3'b000, 3'b000, 1, 32'h0000_0040, 32'h0);
        add(3'b001, 3'b000, 0, 1, 32'h3333_3333,  3'b000, 3'b001, 3'b000, 0, 32'h0,          32'h3333_3333);
        add(3'b000, 3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 3'b001, 0, 32'h0,          32'h0);
        add(3'b000, 3'b000, 0, 0, 32'h0,          3'b000, 3'b000, 3'b000, 0, 32'h0,          32'h0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            {uc_req, dc_req, ic_req} = vq[i].req;
            {uc_wr, dc_wr, ic_wr}    = vq[i].wr;
            bus_addr_ok = vq[i].aok;
            bus_data_ok = vq[i].dok;
            bus_rdata   = vq[i].brd;
            #1;
            chk($sformatf("v%0d.grant", i),  32'(gnt3()),  32'(vq[i].gnt));
            chk($sformatf("v%0d.rvalid", i), 32'(rv3()),   32'(vq[i].rv));
            chk($sformatf("v%0d.fin", i),    32'(fin3()),  32'(vq[i].fin));
            chk($sformatf("v%0d.bus_req", i), 32'(bus_req), 32'(vq[i].breq));
            if (vq[i].breq)
                chk($sformatf("v%0d.bus_addr", i), bus_addr, vq[i].baddr);
            if (vq[i].rv != 3'b000)
                chk($sformatf("v%0d.rdata", i), rdata, vq[i].rdat);
        end

        // dc burst write: 8 beats at 0x1220..0x123C, no rvalid, one fin
        @(negedge clk);
        drive_idle();
        {uc_wr, dc_wr, ic_wr} = 3'b010;
        dc_burst = 1'b1; dc_size = 2'b00;
        dc_req = 1'b1;
        #1 chk("bw.grant", 32'(gnt3()), 32'b010);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
            dc_wdata = 32'hA000_0000 + 32'(b);
            #1;
            chk($sformatf("bw%0d.bus_ctl", b), 32'({bus_req, bus_wr, bus_size}), 32'b1110);
            chk($sformatf("bw%0d.bus_addr", b), bus_addr, 32'h0000_1220 + 32'(4 * b));
            chk($sformatf("bw%0d.bus_wdata", b), bus_wdata, 32'hA000_0000 + 32'(b));
            chk($sformatf("bw%0d.beat", b), 32'(beat), 32'(b));
            @(negedge clk);
            bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
            #1;
            chk($sformatf("bw%0d.rv_fin", b), 32'({rv3(), fin3()}), 32'h0);
        end
        @(negedge clk);
        drive_idle();
        #1 chk("bw.fin", 32'(fin3()), 32'b010);
        @(negedge clk);
        #1 chk("bw.idle", 32'({gnt3(), fin3(), bus_req}), 32'h0);
        dc_burst = 1'b0; dc_size = 2'b10; dc_wr = 1'b0;

        // ic burst read with addr_ok 3 cycles late and a stray data_ok in ADDR
        @(negedge clk);
        ic_addr = 32'h1000_0104; ic_burst = 1'b1; ic_wr = 1'b0;
        ic_req = 1'b1;
        #1 chk("br.grant", 32'(gnt3()), 32'b001);
        n_rv = 0;
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < 3; w++) begin
                @(negedge clk);
                bus_addr_ok = 1'b0;
                bus_data_ok = (w == 0);
                bus_rdata   = 32'hBAD0_0000;
                #1;
                chk($sformatf("br%0d.wait%0d", b, w), 32'({bus_req, rv3()}), 32'b1000);
                chk($sformatf("br%0d.wait_addr%0d", b, w), bus_addr, 32'h1000_0100 + 32'(4 * b));
            end
            @(negedge clk);
            bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
            #1 chk($sformatf("br%0d.aok_beat", b), 32'({bus_req, beat}), 32'({1'b1, 3'(b)}));
            @(negedge clk);
            bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
            bus_rdata = 32'h5A00_0000 + 32'(b);
            #1;
            if (ic_rvalid) n_rv++;
            chk($sformatf("br%0d.rvalid", b), 32'(rv3()), 32'b001);
            chk($sformatf("br%0d.rdata", b), rdata, 32'h5A00_0000 + 32'(b));
            chk($sformatf("br%0d.beat", b), 32'(beat), 32'(b));
        end
        @(negedge clk);
        drive_idle();
        #1 chk("br.fin", 32'(fin3()), 32'b001);
        chk("br.rv_count", 32'(n_rv), 32'd8);
        ic_burst = 1'b0; ic_addr = 32'h0000_0040;

        // reset during beat 3 of a dc burst read, ic_req held throughout
        @(negedge clk);
        dc_addr = 32'h0000_2000; dc_burst = 1'b1; dc_wr = 1'b0;
        dc_req = 1'b1; ic_req = 1'b1;
        #1 chk("rr.grant", 32'(gnt3()), 32'b010);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
            #1 chk($sformatf("rr%0d.addr", b), bus_addr, 32'h0000_2000 + 32'(4 * b));
            @(negedge clk);
            bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'(b);
            #1 chk($sformatf("rr%0d.rvalid", b), 32'(rv3()), 32'b010);
        end
        @(negedge clk);
        bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
        #1 chk("rr3.beat", 32'(beat), 32'd3);
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        resetn = 1'b0;
        #1;
        chk("rr.rst_ctl", 32'({gnt3(), rv3(), fin3(), bus_req, bus_wr, bus_size, beat}), 32'h0);
        chk("rr.rst_addr", bus_addr, 32'h0);
        chk("rr.rst_rdata", rdata, 32'h0);
        @(negedge clk);
        #1 chk("rr.rst_hold", 32'({gnt3(), rv3(), fin3(), bus_req}), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        dc_req = 1'b0; bus_data_ok = 1'b0; dc_burst = 1'b0;
        #1 chk("rr.regrant", 32'({gnt3(), fin3()}), 32'({3'b001, 3'b000}));
        @(negedge clk);
        bus_addr_ok = 1'b1;
        #1 chk("rr.ic_addr", bus_addr, 32'h0000_0040);
        @(negedge clk);
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0055;
        #1 chk("rr.ic_rdata", 32'({rv3(), rdata}), {3'b001, 32'h0000_0055});
        @(negedge clk);
        drive_idle();
        #1 chk("rr.ic_fin", 32'(fin3()), 32'b001);
        @(negedge clk);
        #1 chk("rr.idle", 32'({gnt3(), fin3(), bus_req}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
